// File: rtl/frame_pkg.sv
// Shared constants, state encoding and pixel-beat type for the frame reader.
// Optional x/y beat fields are compiled in with FRAME_READER_XY_EN.
package frame_pkg;

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned ADDR_W       = 15;
  localparam int unsigned WIDTH        = 160;
  localparam int unsigned HEIGHT       = 120;
  localparam int unsigned FRAME_PIXELS = WIDTH * HEIGHT;
  localparam int unsigned X_W          = 8;
  localparam int unsigned Y_W          = 7;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [X_W-1:0]    LAST_COL  = X_W'(WIDTH - 1);

  typedef logic [1:0] rd_state_t;
  localparam rd_state_t IDLE  = 2'd0;
  localparam rd_state_t READ  = 2'd1;
  localparam rd_state_t DRAIN = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
`ifdef FRAME_READER_XY_EN
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
`endif
  } pix_beat_t;

endpackage

// File: rtl/frame_reader_if.sv
// Memory read port plus downstream pixel stream of the frame reader.
// FRAME_READER_XY_EN adds the m_x/m_y/m_eol sideband.
interface frame_reader_if;
  import frame_pkg::*;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
`ifdef FRAME_READER_XY_EN
  logic [X_W-1:0]    m_x;
  logic [Y_W-1:0]    m_y;
  logic              m_eol;

  modport master (
    output mem_en, mem_addr, m_data, m_valid, m_last, m_x, m_y, m_eol,
    input  mem_dout, m_ready
  );
  modport slave (
    input  mem_en, mem_addr, m_data, m_valid, m_last, m_x, m_y, m_eol,
    output mem_dout, m_ready
  );
`else
  modport master (
    output mem_en, mem_addr, m_data, m_valid, m_last,
    input  mem_dout, m_ready
  );
  modport slave (
    input  mem_en, mem_addr, m_data, m_valid, m_last,
    output mem_dout, m_ready
  );
`endif

endinterface

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO whose head is a flop, so the output beat never glitches
// while the consumer stalls. Push and pop may coincide at any occupancy.
module pix_skid_fifo
  import frame_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  pix_beat_t push_beat,
  input  logic      pop,
  output pix_beat_t head,
  output logic [1:0] count
);

  pix_beat_t  slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0] count_q, count_d, push_pos;
  logic       do_pop, do_push;

  assign do_pop   = pop && (count_q != 2'd0);
  assign do_push  = push && ((count_q != 2'd2) || do_pop);
  // Slot the new beat lands in once this cycle's pop has shifted the queue.
  assign push_pos = count_q - {1'b0, do_pop};

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (do_pop) slot0_d = slot1_q;
      if (do_push) begin
        if (push_pos == 2'd0) slot0_d = push_beat;
        else                  slot1_d = push_beat;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head  = slot0_q;
  assign count = count_q;

endmodule

// File: rtl/frame_reader.sv
// Streams one stored frame in raster order from the frame memory read port.
// Define FRAME_READER_XY_EN to add per-pixel x/y and end-of-line outputs.
module frame_reader
  import frame_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  frame_reader_if.master bus
);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              done_q, done_d;
  logic [1:0]        count;
  logic [2:0]        occ_sum;
  logic              pop, issue, kill;
  pix_beat_t         head, push_beat;
`ifdef FRAME_READER_XY_EN
  logic [X_W-1:0]    col_q, col_d, inflight_x_q;
  logic [Y_W-1:0]    row_q, row_d, inflight_y_q;
`endif

  assign busy    = (state_q != IDLE);
  assign kill    = busy && abort;
  assign pop     = bus.m_valid && bus.m_ready;
  assign occ_sum = {1'b0, count} + {2'b00, inflight_q};
  // Only issue when the landing beat is guaranteed a free slot.
  assign issue   = (state_q == READ) && (occ_sum < (3'd2 + {2'b00, pop}));

  assign bus.mem_en   = issue;
  assign bus.mem_addr = addr_q;
  assign done         = done_q;

  always_comb begin
    push_beat      = '0;
    push_beat.data = bus.mem_dout;
    push_beat.last = inflight_last_q;
`ifdef FRAME_READER_XY_EN
    push_beat.x    = inflight_x_q;
    push_beat.y    = inflight_y_q;
`endif
  end

  pix_skid_fifo u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (kill),
    .push      (inflight_q),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign bus.m_valid = (count != 2'd0);
  assign bus.m_data  = head.data;
  assign bus.m_last  = head.last;
`ifdef FRAME_READER_XY_EN
  assign bus.m_x   = head.x;
  assign bus.m_y   = head.y;
  assign bus.m_eol = (head.x == LAST_COL);
`endif

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    done_d          = 1'b0;
    inflight_d      = issue && !kill;
    inflight_last_d = issue && (addr_q == LAST_ADDR);
`ifdef FRAME_READER_XY_EN
    col_d = col_q;
    row_d = row_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = READ;
          addr_d  = '0;
`ifdef FRAME_READER_XY_EN
          col_d = '0;
          row_d = '0;
`endif
        end
      end
      READ: begin
        if (issue) begin
          if (addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
`ifdef FRAME_READER_XY_EN
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + Y_W'(1);
            end else begin
              col_d = col_q + X_W'(1);
            end
`endif
          end
        end
      end
      DRAIN: begin
        if (pop && head.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

`ifdef FRAME_READER_XY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      inflight_x_q <= '0;
      inflight_y_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (issue) begin
        inflight_x_q <= col_q;
        inflight_y_q <= row_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: table of frame scenarios plus hand-written corner
// sequences; the memory model returns ram[i] = i. Honours FRAME_READER_XY_EN.
module tb_frame_reader;

  localparam int ModeAlways  = 0;
  localparam int ModeToggle  = 1;
  localparam int ModeRand30  = 2;
  localparam int ModeStall50 = 3;

  typedef struct {
    string name;
    int    mode;
    int    abort_at;
    bit    extra_start;
    int    exp_beats;
    int    exp_done;
    int    exp_last;
  } vec_t;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic busy;
  logic done;

  int n_cmp = 0;
  int n_err = 0;

  // Monitor-owned per-frame state.
  int   frame_beats = 0;
  int   frame_done  = 0;
  int   frame_last  = 0;
  int   issued      = 0;
  bit   prev_stall  = 0;
  bit   prev_last_hs = 0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;

  frame_reader_if bus ();

  frame_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory with ram[i] = i.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_dout <= {1'b0, bus.mem_addr};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      ModeToggle:  return (cyc % 2) == 0;
      ModeRand30:  return $urandom_range(0, 99) >= 30;
      ModeStall50: return cyc >= 50;
      default:     return 1'b1;
    endcase
  endfunction

  // Stream scoreboard, sampled on the falling edge.
  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall   = 0;
        prev_last_hs = 0;
      end else begin
        if (start && !busy && !abort) begin
          frame_beats  = 0;
          frame_done   = 0;
          frame_last   = 0;
          issued       = 0;
          prev_stall   = 0;
          prev_last_hs = 0;
        end
        if (done) begin
          frame_done++;
          check("done_after_last", 32'(prev_last_hs), 32'd1);
          check("busy_low_with_done", 32'(busy), 32'd0);
        end
        if (prev_stall) begin
          check("stall_valid_held", 32'(bus.m_valid), 32'd1);
          check("stall_data_held", 32'(bus.m_data), 32'(prev_data));
          check("stall_last_held", 32'(bus.m_last), 32'(prev_last));
        end
        if (bus.mem_en) issued++;
        hs = bus.m_valid && bus.m_ready;
        if (hs) begin
          check("beat_data", 32'(bus.m_data), 32'(frame_beats));
          check("beat_last", 32'(bus.m_last), 32'(frame_beats == 19199));
`ifdef FRAME_READER_XY_EN
          check("beat_x", 32'(bus.m_x), 32'(frame_beats % 160));
          check("beat_y", 32'(bus.m_y), 32'(frame_beats / 160));
          check("beat_eol", 32'(bus.m_eol), 32'((frame_beats % 160) == 159));
`endif
          if (bus.m_last) frame_last++;
          frame_beats++;
        end
        if (busy) check("no_overfill", 32'((issued - frame_beats) <= 2), 32'd1);
        prev_stall   = bus.m_valid && !bus.m_ready && !abort;
        prev_data    = bus.m_data;
        prev_last    = bus.m_last;
        prev_last_hs = hs && bus.m_last;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    check({tag, "_m_data"}, 32'(bus.m_data), 32'd0);
    check({tag, "_m_last"}, 32'(bus.m_last), 32'd0);
`ifdef FRAME_READER_XY_EN
    check({tag, "_m_x"}, 32'(bus.m_x), 32'd0);
    check({tag, "_m_y"}, 32'(bus.m_y), 32'd0);
    check({tag, "_m_eol"}, 32'(bus.m_eol), 32'd0);
`endif
  endtask

  task automatic run_frame(input vec_t v);
    bit aborted  = 0;
    bit finished = 0;
    int post     = 0;
    bus.m_ready = ready_for(v.mode, -1);
    pulse_start();
    check({v.name, "_busy_on_start"}, 32'(busy), 32'd1);
    check({v.name, "_start_addr"}, 32'(bus.mem_addr), 32'd0);
    for (int cyc = 0; cyc < 45000 && !finished; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (cyc == 0) check({v.name, "_valid_early"}, 32'(bus.m_valid), 32'd0);
      if (cyc == 1) begin
        check({v.name, "_first_valid"}, 32'(bus.m_valid), 32'd1);
        check({v.name, "_first_data"}, 32'(bus.m_data), 32'd0);
      end
      if (aborted) begin
        post++;
        if (post == 1) begin
          check({v.name, "_abort_busy"}, 32'(busy), 32'd0);
          check({v.name, "_abort_valid"}, 32'(bus.m_valid), 32'd0);
        end
        if (post == 5) finished = 1;
      end
      bus.m_ready = ready_for(v.mode, cyc);
      if (v.mode == ModeStall50 && cyc == 45) begin
        check("stall50_mem_addr", 32'(bus.mem_addr), 32'd2);
        check("stall50_issued", 32'(issued), 32'd2);
      end
      if (v.extra_start && (frame_beats == 100 || frame_beats == 19199)) start = 1'b1;
      if (!aborted && v.abort_at >= 0 && frame_beats == v.abort_at) begin
        abort       = 1'b1;
        bus.m_ready = 1'b0;
        aborted     = 1;
      end
      if (frame_done != 0) finished = 1;
    end
    check({v.name, "_timeout"}, 32'(finished), 32'd1);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({v.name, "_beats"}, 32'(frame_beats), 32'(v.exp_beats));
    check({v.name, "_done_count"}, 32'(frame_done), 32'(v.exp_done));
    check({v.name, "_last_count"}, 32'(frame_last), 32'(v.exp_last));
    check({v.name, "_idle_after"}, 32'(busy), 32'd0);
    check({v.name, "_quiet_after"}, 32'(bus.mem_en), 32'd0);
  endtask

  initial begin
    vec_t vecs[4];
    vecs[0] = '{name: "full_ready",  mode: ModeAlways,  abort_at: -1,  extra_start: 1'b1,
                exp_beats: 19200, exp_done: 1, exp_last: 1};
    vecs[1] = '{name: "toggle_abort", mode: ModeToggle, abort_at: 500, extra_start: 1'b0,
                exp_beats: 500, exp_done: 0, exp_last: 0};
    vecs[2] = '{name: "rand30_full", mode: ModeRand30,  abort_at: -1,  extra_start: 1'b0,
                exp_beats: 19200, exp_done: 1, exp_last: 1};
    vecs[3] = '{name: "stall50",     mode: ModeStall50, abort_at: 300, extra_start: 1'b0,
                exp_beats: 300, exp_done: 0, exp_last: 0};

    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // start and abort together while idle: abort wins.
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("start_abort_busy", 32'(busy), 32'd0);
      check("start_abort_mem_en", 32'(bus.mem_en), 32'd0);
      check("start_abort_valid", 32'(bus.m_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a frame.
    bus.m_ready = 1'b1;
    pulse_start();
    repeat (30) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_idle", 32'(busy), 32'd0);
    pulse_start();
    check("restart_addr", 32'(bus.mem_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("restart_valid", 32'(bus.m_valid), 32'd1);
    check("restart_data", 32'(bus.m_data), 32'd0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("restart_abort_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
